// File: rtl/iommu_cfg_pkg.sv
// Shared definitions for the IOMMU configuration AXI4-Lite bridge.
//   - AXI response encodings
//   - bridge FSM state enum
//   - default IOMMU programming window taken from the SoC address map
package iommu_cfg_pkg;

    // SoC address-map constants for the IOMMU programming window.
    localparam logic [63:0] IOMMU_BASE   = 64'h0000_0000_5001_0000;
    localparam logic [63:0] IOMMU_LENGTH = 64'h0000_0000_0000_1000;

    // AXI response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ACC,
        WR_RESP,
        RD_ACC,
        RD_RESP
    } state_e;

endpackage

// File: rtl/iommu_cfg_addr_decode.sv
// Combinational address check for the IOMMU programming window.
// Ports:
//   addr    in   AXI byte address
//   decerr  out  address lies outside [BaseAddr, BaseAddr+WinLength)
//   slverr  out  address is inside the window but not aligned to DataWidth
//   offset  out  byte offset of addr within the window
module iommu_cfg_addr_decode
    import iommu_cfg_pkg::*;
#(
    parameter int          AddrWidth = 64,
    parameter int          DataWidth = 64,
    parameter logic [63:0] BaseAddr  = IOMMU_BASE,
    parameter logic [63:0] WinLength = IOMMU_LENGTH,
    parameter int          OffWidth  = 12
) (
    input  logic [AddrWidth-1:0] addr,
    output logic                 decerr,
    output logic                 slverr,
    output logic [OffWidth-1:0]  offset
);

    localparam int                   AlignBits = $clog2(DataWidth / 8);
    localparam logic [AddrWidth-1:0] Base      = BaseAddr[AddrWidth-1:0];
    localparam logic [AddrWidth-1:0] Len       = WinLength[AddrWidth-1:0];

    logic [AddrWidth-1:0] rel;
    logic                 in_window;
    logic                 aligned;

    // The window test uses a subtraction rather than Base+Len so that a
    // window ending at the top of the address space cannot wrap.
    always_comb begin
        rel       = addr - Base;
        in_window = (addr >= Base) && (rel < Len);
        aligned   = (addr[AlignBits-1:0] == '0);
        decerr    = !in_window;
        slverr    = in_window && !aligned;
        offset    = rel[OffWidth-1:0];
    end

endmodule

// File: rtl/iommu_cfg_axil_bridge.sv
// AXI4-Lite slave to register-bus master bridge for the IOMMU_CFG crossbar
// slave port. One transaction in flight; out-of-window accesses answer
// DECERR, misaligned in-window accesses answer SLVERR, and only clean
// accesses reach the register bus as window offsets.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   aw_*/w_*/b_*                    AXI4-Lite write address/data/response
//   ar_*/r_*                        AXI4-Lite read address/data
//   reg_req_o/reg_we_o/reg_addr_o   register request, direction, offset
//   reg_wdata_o/reg_wstrb_o         register write data and strobes
//   reg_ready_i/reg_rdata_i/reg_error_i  register completion, data, error
// Build option: define IOMMU_CFG_BRIDGE_TIMEOUT_EN to add a watchdog that
// ends an access with SLVERR after TimeoutCycles cycles without reg_ready_i.
module iommu_cfg_axil_bridge
    import iommu_cfg_pkg::*;
#(
    parameter int          AddrWidth     = 64,
    parameter int          DataWidth     = 64,
    parameter logic [63:0] BaseAddr      = IOMMU_BASE,
    parameter logic [63:0] WinLength     = IOMMU_LENGTH,
    parameter int          OffWidth      = 12,
    parameter int          TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [1:0]             b_resp_o,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   reg_req_o,
    output logic                   reg_we_o,
    output logic [OffWidth-1:0]    reg_addr_o,
    output logic [DataWidth-1:0]   reg_wdata_o,
    output logic [DataWidth/8-1:0] reg_wstrb_o,
    input  logic                   reg_ready_i,
    input  logic [DataWidth-1:0]   reg_rdata_i,
    input  logic                   reg_error_i
);

    localparam int StrbWidth = DataWidth / 8;

    state_e                 state_q, state_d;
    logic                   prio_wr_q;     // 1: write wins the next tie
    logic [OffWidth-1:0]    off_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [StrbWidth-1:0]   wstrb_q;
    logic [DataWidth-1:0]   rdata_q;
    logic [1:0]             resp_q;

    logic                   wr_cand, rd_cand;
    logic                   grant_wr, grant_rd;
    logic                   in_acc;
    logic                   tmo_expire;
    logic [AddrWidth-1:0]   dec_addr;
    logic                   dec_decerr, dec_slverr;
    logic [OffWidth-1:0]    dec_off;

    // NOTE: every signal written in an always_comb gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        wr_cand  = aw_valid_i && w_valid_i;
        rd_cand  = ar_valid_i;
        grant_wr = (state_q == IDLE) && wr_cand && (!rd_cand || prio_wr_q);
        grant_rd = (state_q == IDLE) && rd_cand && (!wr_cand || !prio_wr_q);
        // Decode the address being latched this cycle so an error response
        // can be raised on the very next cycle.
        dec_addr = grant_wr ? aw_addr_i : ar_addr_i;
        in_acc   = (state_q == WR_ACC) || (state_q == RD_ACC);
    end

    iommu_cfg_addr_decode #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .BaseAddr  (BaseAddr),
        .WinLength (WinLength),
        .OffWidth  (OffWidth)
    ) u_decode (
        .addr   (dec_addr),
        .decerr (dec_decerr),
        .slverr (dec_slverr),
        .offset (dec_off)
    );

`ifdef IOMMU_CFG_BRIDGE_TIMEOUT_EN
    localparam int                  TmoWidth = $clog2(TimeoutCycles + 1);
    localparam logic [TmoWidth-1:0] TmoLast  = TmoWidth'(TimeoutCycles - 1);

    logic [TmoWidth-1:0] tmo_q;

    // Counts ACC cycles; clears whenever the FSM is outside an ACC state.
    always_ff @(posedge clk_i) begin
        if (rst_i || !in_acc) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // A completion in the expiry cycle wins over the watchdog.
    assign tmo_expire = in_acc && (tmo_q == TmoLast) && !reg_ready_i;
`else
    assign tmo_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        ar_ready_o = 1'b0;
        reg_req_o  = 1'b0;
        reg_we_o   = 1'b0;
        b_valid_o  = 1'b0;
        r_valid_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    aw_ready_o = 1'b1;
                    w_ready_o  = 1'b1;
                    state_d    = (dec_decerr || dec_slverr) ? WR_RESP : WR_ACC;
                end else if (grant_rd) begin
                    ar_ready_o = 1'b1;
                    state_d    = (dec_decerr || dec_slverr) ? RD_RESP : RD_ACC;
                end
            end
            WR_ACC: begin
                reg_req_o = 1'b1;
                reg_we_o  = 1'b1;
                if (reg_ready_i || tmo_expire) state_d = WR_RESP;
            end
            RD_ACC: begin
                reg_req_o = 1'b1;
                if (reg_ready_i || tmo_expire) state_d = RD_RESP;
            end
            WR_RESP: begin
                b_valid_o = 1'b1;
                if (b_ready_i) state_d = IDLE;
            end
            RD_RESP: begin
                r_valid_o = 1'b1;
                if (r_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_wr_q <= 1'b1;
            off_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else if (grant_wr || grant_rd) begin
            prio_wr_q <= !prio_wr_q;
            off_q     <= dec_off;
            wdata_q   <= grant_wr ? w_data_i : '0;
            wstrb_q   <= grant_wr ? w_strb_i : '0;
            rdata_q   <= '0;
            resp_q    <= dec_decerr ? RESP_DECERR
                       : (dec_slverr ? RESP_SLVERR : RESP_OKAY);
        end else if (in_acc && reg_ready_i) begin
            resp_q  <= reg_error_i ? RESP_SLVERR : RESP_OKAY;
            rdata_q <= (state_q == RD_ACC && !reg_error_i) ? reg_rdata_i : '0;
        end else if (tmo_expire) begin
            resp_q  <= RESP_SLVERR;
            rdata_q <= '0;
        end
    end

    assign reg_addr_o  = off_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;
    assign b_resp_o    = (state_q == WR_RESP) ? resp_q : RESP_OKAY;
    assign r_resp_o    = (state_q == RD_RESP) ? resp_q : RESP_OKAY;
    assign r_data_o    = (state_q == RD_RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_iommu_cfg_axil_bridge.sv
// Self-checking bench for iommu_cfg_axil_bridge: directed vector table,
// hand sequences for lone handshakes, reset mid-access and write/read ties,
// then randomized transactions checked against a window/latency model.
`timescale 1ns/1ps
module tb_iommu_cfg_axil_bridge;

    localparam int          TMO  = 8;
    localparam logic [63:0] BASE = 64'h5001_0000;
    localparam logic [63:0] LEN  = 64'h1000;
    localparam logic [1:0]  OKAY = 2'd0, SLV = 2'd2, DEC = 2'd3;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        aw_valid_i = 0, w_valid_i = 0, ar_valid_i = 0;
    logic        b_ready_i = 0, r_ready_i = 0;
    logic        reg_ready_i = 0, reg_error_i = 0;
    logic [63:0] aw_addr_i = 0, ar_addr_i = 0, w_data_i = 0, reg_rdata_i = 0;
    logic [7:0]  w_strb_i = 0;
    logic        aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o;
    logic        reg_req_o, reg_we_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic [63:0] r_data_o, reg_wdata_o;
    logic [11:0] reg_addr_o;
    logic [7:0]  reg_wstrb_o;

    iommu_cfg_axil_bridge #(.TimeoutCycles(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
        .reg_req_o(reg_req_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
        .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One AXI operation; lat = ACC cycles before reg_ready_i (-1 = never),
    // rwait = cycles the response is left waiting before ready.
    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        int          lat;
        bit          err;
        logic [63:0] rdata;
        int          rwait;
    } op_t;

    typedef struct {
        bit          is_wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        int          lat;
        bit          err;
        logic [63:0] rdata;
        logic [1:0]  exp_resp;
        logic [63:0] exp_data;
        int          exp_lat;
        bit          exp_req;
        logic [11:0] exp_off;
    } vec_t;

    // Index 0 = read, 1 = write.
    op_t         ops[2];
    bit          want[2];
    int          g_cyc[2], v_cyc[2], h_cyc[2], acc_n[2];
    logic [1:0]  got_resp[2];
    logic [63:0] got_data[2];
    bit          saw_req[2], req_bad[2], pay_bad[2];
    logic [11:0] req_addr[2];
    logic        req_we[2];
    logic [63:0] req_wdata[2];
    logic [7:0]  req_strb[2];
    int          first_dir;
    bit          run_ok;
    bit          prio_wr;   // model: 1 = write wins the next tie

    // Drives the wanted operations, answers the register bus and the response
    // channels, and records what the DUT did. Entered and left at posedge+1.
    task automatic run();
        bit pend[2];
        int cur, vn;
        bit done;
        pend[0] = want[0]; pend[1] = want[1];
        cur = -1; vn = 0; first_dir = -1; run_ok = 0;
        for (int d = 0; d < 2; d++) begin
            g_cyc[d] = -1; v_cyc[d] = -1; h_cyc[d] = -1; acc_n[d] = 0;
            saw_req[d] = 0; req_bad[d] = 0; pay_bad[d] = 0;
            got_resp[d] = 0; got_data[d] = 0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            aw_valid_i = pend[1]; w_valid_i = pend[1];
            aw_addr_i = ops[1].addr; w_data_i = ops[1].wdata; w_strb_i = ops[1].strb;
            ar_valid_i = pend[0]; ar_addr_i = ops[0].addr;
            reg_ready_i = 0; reg_error_i = 0; reg_rdata_i = {$urandom, $urandom};
            b_ready_i = 0; r_ready_i = 0;
            if (cur >= 0 && reg_req_o) begin
                if (acc_n[cur] == ops[cur].lat) begin
                    reg_ready_i = 1; reg_error_i = ops[cur].err; reg_rdata_i = ops[cur].rdata;
                end
                acc_n[cur]++;
            end
            if (cur >= 0 && (b_valid_o || r_valid_o)) begin
                if (vn >= ops[cur].rwait) begin
                    b_ready_i = (cur == 1); r_ready_i = (cur == 0);
                end
                vn++;
            end
            @(negedge clk_i);
            done = 0;
            if (cur < 0) begin
                if (pend[1] && aw_ready_o && w_ready_o) cur = 1;
                else if (pend[0] && ar_ready_o) cur = 0;
                if (cur >= 0) begin
                    g_cyc[cur] = cyc; pend[cur] = 0; vn = 0; prio_wr = !prio_wr;
                    if (first_dir < 0) first_dir = cur;
                end
            end else begin
                if (aw_ready_o || w_ready_o || ar_ready_o) pay_bad[cur] = 1;
                if (reg_req_o) begin
                    if (!saw_req[cur]) begin
                        saw_req[cur] = 1; req_addr[cur] = reg_addr_o; req_we[cur] = reg_we_o;
                        req_wdata[cur] = reg_wdata_o; req_strb[cur] = reg_wstrb_o;
                    end else if (reg_addr_o !== req_addr[cur] || reg_we_o !== req_we[cur] ||
                                 reg_wdata_o !== req_wdata[cur] || reg_wstrb_o !== req_strb[cur]) begin
                        req_bad[cur] = 1;
                    end
                end
                if (cur == 1 ? r_valid_o : b_valid_o) pay_bad[cur] = 1;
                if (cur == 1 ? b_valid_o : r_valid_o) begin
                    if (v_cyc[cur] < 0) begin
                        v_cyc[cur] = cyc;
                        got_resp[cur] = (cur == 1) ? b_resp_o : r_resp_o;
                        got_data[cur] = (cur == 1) ? 64'd0 : r_data_o;
                    end else if (got_resp[cur] !== ((cur == 1) ? b_resp_o : r_resp_o) ||
                                 (cur == 0 && got_data[cur] !== r_data_o)) begin
                        pay_bad[cur] = 1;
                    end
                    if (cur == 1 ? b_ready_i : r_ready_i) begin
                        h_cyc[cur] = cyc; cur = -1;
                        done = !pend[0] && !pend[1];
                    end
                end
            end
            @(posedge clk_i); #1;
            if (done) begin
                run_ok = 1;
                break;
            end
        end
        aw_valid_i = 0; w_valid_i = 0; ar_valid_i = 0;
        b_ready_i = 0; r_ready_i = 0; reg_ready_i = 0; reg_error_i = 0;
    endtask

    // Reference model: window/alignment rules and access latency.
    function automatic void model(input int d, input op_t o, output logic [1:0] r,
                                  output logic [63:0] dat, output bit fwd, output int lat);
        bit inwin, algn;
        inwin = (o.addr >= BASE) && (o.addr < BASE + LEN);
        algn  = (o.addr % 8) == 0;
        dat = 0; fwd = 0; r = OKAY; lat = 1;
        if (!inwin) begin
            r = DEC;
        end else if (!algn) begin
            r = SLV;
        end else begin
            fwd = 1;
`ifdef IOMMU_CFG_BRIDGE_TIMEOUT_EN
            if (o.lat < 0 || o.lat >= TMO) begin
                r = SLV; lat = TMO + 1;
            end else
`endif
            begin
                lat = o.lat + 2;
                r = o.err ? SLV : OKAY;
                if (d == 0 && !o.err) dat = o.rdata;
            end
        end
    endfunction

    task automatic eval(input int d, input string tag);
        logic [1:0]  er;
        logic [63:0] ed;
        bit          fwd;
        int          el;
        model(d, ops[d], er, ed, fwd, el);
        check($sformatf("%s.done", tag), run_ok, 1);
        check($sformatf("%s.resp", tag), got_resp[d], er);
        if (d == 0) check($sformatf("%s.rdata", tag), got_data[d], ed);
        check($sformatf("%s.req", tag), saw_req[d], fwd);
        check($sformatf("%s.latency", tag), v_cyc[d] - g_cyc[d], el);
        if (fwd) begin
            check($sformatf("%s.off", tag), req_addr[d], ops[d].addr - BASE);
            check($sformatf("%s.we", tag), req_we[d], d);
            if (d == 1) begin
                check($sformatf("%s.wdata", tag), req_wdata[d], ops[d].wdata);
                check($sformatf("%s.wstrb", tag), req_strb[d], ops[d].strb);
            end
        end
        check($sformatf("%s.stable", tag), req_bad[d] | pay_bad[d], 0);
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return BASE + 64'($urandom_range(0, 511)) * 8;
            3:       return BASE + 64'($urandom_range(0, 4095));
            4:       return BASE + LEN + 64'($urandom_range(0, 63)) * 8;
            default: return BASE - 64'($urandom_range(1, 64)) * 8;
        endcase
    endfunction

    localparam int NV = 9;
    vec_t vt[NV];

    initial begin
        int d, exp_first;
        bit quiet;

        vt[0] = '{1, 64'h5001_0010, 64'hDEADBEEF_CAFEF00D, 8'hFF, 3, 0, 64'h0, OKAY, 64'h0, 5, 1, 12'h010};
        vt[1] = '{0, 64'h5001_0FF8, 64'h0, 8'h00, 0, 0, 64'h1234, OKAY, 64'h1234, 2, 1, 12'hFF8};
        vt[2] = '{0, 64'h5001_1000, 64'h0, 8'h00, 0, 0, 64'h5555, DEC, 64'h0, 1, 0, 12'h000};
        vt[3] = '{1, 64'h5001_0004, 64'h1111, 8'h0F, 0, 0, 64'h0, SLV, 64'h0, 1, 0, 12'h000};
        vt[4] = '{0, 64'h5000_FFF8, 64'h0, 8'h00, 0, 0, 64'h7777, DEC, 64'h0, 1, 0, 12'h000};
        vt[5] = '{0, 64'h5001_0000, 64'h0, 8'h00, 1, 1, 64'hAAAA, SLV, 64'h0, 3, 1, 12'h000};
        vt[6] = '{1, 64'h5001_0FFF, 64'h2222, 8'hFF, 0, 0, 64'h0, SLV, 64'h0, 1, 0, 12'h000};
        vt[7] = '{0, 64'h5001_0FFC, 64'h0, 8'h00, 0, 0, 64'h9999, SLV, 64'h0, 1, 0, 12'h000};
        vt[8] = '{1, 64'h0000_0100_5001_0010, 64'h3333, 8'h01, 0, 0, 64'h0, DEC, 64'h0, 1, 0, 12'h000};

        // Reset state.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset.ctrl", {aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o,
                             reg_req_o, reg_we_o, b_resp_o, r_resp_o}, 0);
        check("reset.rdata", r_data_o, 0);
        check("reset.regbus", {reg_addr_o, reg_wstrb_o}, 0);
        check("reset.wdata", reg_wdata_o, 0);
        @(posedge clk_i); #1;
        rst_i = 0;
        prio_wr = 1;

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            d = vt[i].is_wr ? 1 : 0;
            ops[d] = '{vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].lat, vt[i].err, vt[i].rdata, i % 3};
            want[0] = (d == 0); want[1] = (d == 1);
            run();
            check($sformatf("vec%0d.done", i), run_ok, 1);
            check($sformatf("vec%0d.resp", i), got_resp[d], vt[i].exp_resp);
            if (d == 0) check($sformatf("vec%0d.rdata", i), got_data[d], vt[i].exp_data);
            check($sformatf("vec%0d.req", i), saw_req[d], vt[i].exp_req);
            check($sformatf("vec%0d.latency", i), v_cyc[d] - g_cyc[d], vt[i].exp_lat);
            if (vt[i].exp_req) begin
                check($sformatf("vec%0d.off", i), req_addr[d], vt[i].exp_off);
                check($sformatf("vec%0d.we", i), req_we[d], vt[i].is_wr);
                if (d == 1) check($sformatf("vec%0d.wdata", i), req_wdata[d], vt[i].wdata);
            end
            check($sformatf("vec%0d.stable", i), req_bad[d] | pay_bad[d], 0);
        end

        // A lone AW or a lone W is never accepted.
        for (int k = 0; k < 2; k++) begin
            aw_valid_i = (k == 0); w_valid_i = (k == 1);
            aw_addr_i = BASE + 64'h40; w_data_i = 64'hABCD; w_strb_i = 8'hFF;
            quiet = 1;
            repeat (6) begin
                @(negedge clk_i);
                if (aw_ready_o || w_ready_o || ar_ready_o || reg_req_o || b_valid_o || r_valid_o) quiet = 0;
                @(posedge clk_i); #1;
            end
            check($sformatf("lone%s.ignored", k == 0 ? "aw" : "w"), quiet, 1);
            aw_valid_i = 0; w_valid_i = 0;
        end

        // Reset in the middle of a register access aborts it.
        aw_valid_i = 1; w_valid_i = 1; aw_addr_i = BASE + 64'h20; w_data_i = 64'h4444; w_strb_i = 8'hFF;
        @(negedge clk_i);
        check("rstacc.grant", aw_ready_o & w_ready_o, 1);
        @(posedge clk_i); #1;
        aw_valid_i = 0; w_valid_i = 0;
        @(negedge clk_i);
        check("rstacc.inacc", reg_req_o, 1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1;
        @(posedge clk_i); #1;
        check("rstacc.ctrl", {aw_ready_o, w_ready_o, ar_ready_o, b_valid_o, r_valid_o,
                              reg_req_o, reg_we_o, b_resp_o, r_resp_o}, 0);
        check("rstacc.regbus", {reg_addr_o, reg_wstrb_o}, 0);
        check("rstacc.data", reg_wdata_o | r_data_o, 0);
        rst_i = 0;
        prio_wr = 1;

        // Write and read tied: write first after reset, then the pending read.
        ops[1] = '{BASE + 64'h100, 64'h0102_0304_0506_0708, 8'hF0, 1, 0, 64'h0, 0};
        ops[0] = '{BASE + 64'h200, 64'h0, 8'h00, 0, 1, 64'hBEEF, 1};
        want[0] = 1; want[1] = 1;
        run();
        check("tie.first", first_dir, 1);
        check("tie.second_grant", g_cyc[0], h_cyc[1] + 1);
        eval(1, "tie.wr");
        eval(0, "tie.rd");

`ifdef IOMMU_CFG_BRIDGE_TIMEOUT_EN
        // Watchdog: no completion, then a completion in the expiry cycle.
        ops[0] = '{BASE + 64'h300, 64'h0, 8'h00, -1, 0, 64'h1, 0};
        want[0] = 1; want[1] = 0;
        run();
        eval(0, "tmo.never");
        ops[1] = '{BASE + 64'h308, 64'h66, 8'h0F, TMO - 1, 0, 64'h0, 0};
        want[0] = 0; want[1] = 1;
        run();
        eval(1, "tmo.edge");
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 2; k++) begin
                ops[k] = '{rand_addr(), {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3),
                           ($urandom_range(0, 3) == 0), {$urandom, $urandom}, $urandom_range(0, 2)};
            end
            case ($urandom_range(0, 2))
                0:       begin want[0] = 1; want[1] = 0; end
                1:       begin want[0] = 0; want[1] = 1; end
                default: begin want[0] = 1; want[1] = 1; end
            endcase
            exp_first = (want[0] && want[1]) ? (prio_wr ? 1 : 0) : (want[1] ? 1 : 0);
            run();
            check($sformatf("rnd%0d.first", i), first_dir, exp_first);
            if (want[0] && want[1])
                check($sformatf("rnd%0d.second_grant", i), g_cyc[1 - exp_first], h_cyc[exp_first] + 1);
            if (want[1]) eval(1, $sformatf("rnd%0d.wr", i));
            if (want[0]) eval(0, $sformatf("rnd%0d.rd", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
